window_ctrl_3x3: RTL and testbench

Sequencer for the 3x3 convolution window register in the Conv2d datapath. It walks a valid-mode (no padding) raster over an IMG_H x IMG_W feature map and issues line-buffer column reads. It drives the window register's Wr_window / Shift_window / Rst_window controls and presents each full window to the MAC stage with a valid/ready handshake. One instance sits between the three-row line buffer and the window register.

---
 rtl/conv2d_pkg.sv | 18 +
 rtl/conv_pos_counter.sv | 61 ++++++
 rtl/window_ctrl_3x3.sv | 131 +++++++++++++
 tb/tb_window_ctrl_3x3.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/conv2d_pkg.sv
// Shared definitions for the Conv2d window sequencing logic.
package conv2d_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_READ  = 3'd2,
        S_LOAD  = 3'd3,
        S_EMIT  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam int WIN_K     = 3;
    localparam int DEF_IMG_W = 16;
    localparam int DEF_IMG_H = 16;
    localparam int DEF_COL_W = 8;

endpackage

// File: rtl/conv_pos_counter.sv
// Column counter and band-row counter for the 3x3 window raster.
// row holds the bottom row of the current 3-row band, so it starts at WIN_K-1.
module conv_pos_counter
    import conv2d_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H,
    parameter int COL_W = DEF_COL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             row_init,
    input  logic             col_clr,
    input  logic             col_inc,
    input  logic             row_inc,
    output logic [COL_W-1:0] col,
    output logic [COL_W-1:0] row,
    output logic             col_tc,
    output logic             row_tc
);

    localparam logic [COL_W-1:0] ROW_FIRST = COL_W'(WIN_K - 1);
    localparam logic [COL_W-1:0] COL_END   = COL_W'(IMG_W);
    localparam logic [COL_W-1:0] ROW_LAST  = COL_W'(IMG_H - 1);

    logic [COL_W-1:0] col_q, col_d;
    logic [COL_W-1:0] row_q, row_d;

    // Next-state for both counters; clear/init takes priority over increment.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (col_clr) begin
            col_d = '0;
        end else if (col_inc) begin
            col_d = col_q + 1'b1;
        end
        if (row_init) begin
            row_d = ROW_FIRST;
        end else if (row_inc) begin
            row_d = row_q + 1'b1;
        end
    end

    // Counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= ROW_FIRST;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign col    = col_q;
    assign row    = row_q;
    assign col_tc = (col_q == COL_END);
    assign row_tc = (row_q == ROW_LAST);

endmodule

// File: rtl/window_ctrl_3x3.sv
// Sequencer for the 3x3 convolution window register: walks a valid-mode
// raster, issues line-buffer column reads, drives window write/shift/clear
// and presents each full window to the MAC stage with valid/ready.
// All outputs are decoded from registered state and counters only.
module window_ctrl_3x3
    import conv2d_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H,
    parameter int COL_W = DEF_COL_W
) (
    input  logic             clk,
    input  logic             Rst_ctrl,
    input  logic             start,
    input  logic             out_ready,
    output logic             rd_en,
    output logic [COL_W-1:0] rd_col,
    output logic [COL_W-1:0] rd_row,
    output logic             Wr_window,
    output logic             Shift_window,
    output logic             Rst_window,
    output logic             window_valid,
    output logic [COL_W-1:0] out_row,
    output logic [COL_W-1:0] out_col,
    output logic             busy,
    output logic             done
);

    state_t           state_q, state_d;
    logic [1:0]       fill_q, fill_d;
    logic             row_init, col_clr, col_inc, row_inc;
    logic [COL_W-1:0] col, row;
    logic             col_tc, row_tc;

    conv_pos_counter #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .COL_W (COL_W)
    ) u_pos (
        .clk      (clk),
        .rst_n    (Rst_ctrl),
        .row_init (row_init),
        .col_clr  (col_clr),
        .col_inc  (col_inc),
        .row_inc  (row_inc),
        .col      (col),
        .row      (row),
        .col_tc   (col_tc),
        .row_tc   (row_tc)
    );

    // Next-state, counter commands and output decode from the current state.
    always_comb begin
        state_d      = state_q;
        fill_d       = fill_q;
        row_init     = 1'b0;
        col_clr      = 1'b0;
        col_inc      = 1'b0;
        row_inc      = 1'b0;
        rd_en        = 1'b0;
        rd_col       = '0;
        rd_row       = '0;
        Wr_window    = 1'b0;
        Shift_window = 1'b0;
        Rst_window   = 1'b1;
        window_valid = 1'b0;
        out_row      = '0;
        out_col      = '0;
        done         = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                row_init = 1'b1;
                if (start) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                Rst_window = 1'b0;
                col_clr    = 1'b1;
                fill_d     = 2'd0;
                state_d    = S_READ;
            end
            S_READ: begin
                rd_en   = 1'b1;
                rd_col  = col;
                rd_row  = row;
                state_d = S_LOAD;
            end
            S_LOAD: begin
                Wr_window    = 1'b1;
                Shift_window = 1'b1;
                col_inc      = 1'b1;
                // fill counts loaded columns and saturates once the window is full
                fill_d       = (fill_q == 2'd3) ? 2'd3 : fill_q + 2'd1;
                state_d      = (fill_d == 2'd3) ? S_EMIT : S_READ;
            end
            S_EMIT: begin
                window_valid = 1'b1;
                out_row      = row - COL_W'(WIN_K - 1);
                out_col      = col - COL_W'(WIN_K);
                if (out_ready) begin
                    if (!col_tc) begin
                        state_d = S_READ;
                    end else if (!row_tc) begin
                        row_inc = 1'b1;
                        state_d = S_CLEAR;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and fill registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!Rst_ctrl) begin
            state_q <= S_IDLE;
            fill_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
        end
    end

    assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_window_ctrl_3x3.sv
// Directed bench for window_ctrl_3x3: a 4x4 instance with a line-buffer and
// window-register model over a ramp image, plus a 3x5 instance for band edges.
module tb_window_ctrl_3x3;

    logic       clk;
    logic       Rst_ctrl;
    logic       start, out_ready;
    logic       rd_en, Wr_window, Shift_window, Rst_window, window_valid, busy, done;
    logic [7:0] rd_col, rd_row, out_row, out_col;

    logic       start_b;
    logic       rd_en_b, Wr_b, Shift_b, Rst_window_b, valid_b, busy_b, done_b;
    logic [7:0] rd_col_b, rd_row_b, out_row_b, out_col_b;

    int n_checks = 0;
    int n_errors = 0;

    window_ctrl_3x3 #(.IMG_W(4), .IMG_H(4), .COL_W(8)) u_a (
        .clk(clk), .Rst_ctrl(Rst_ctrl), .start(start), .out_ready(out_ready),
        .rd_en(rd_en), .rd_col(rd_col), .rd_row(rd_row),
        .Wr_window(Wr_window), .Shift_window(Shift_window), .Rst_window(Rst_window),
        .window_valid(window_valid), .out_row(out_row), .out_col(out_col),
        .busy(busy), .done(done)
    );

    window_ctrl_3x3 #(.IMG_W(3), .IMG_H(5), .COL_W(8)) u_b (
        .clk(clk), .Rst_ctrl(Rst_ctrl), .start(start_b), .out_ready(1'b1),
        .rd_en(rd_en_b), .rd_col(rd_col_b), .rd_row(rd_row_b),
        .Wr_window(Wr_b), .Shift_window(Shift_b), .Rst_window(Rst_window_b),
        .window_valid(valid_b), .out_row(out_row_b), .out_col(out_col_b),
        .busy(busy_b), .done(done_b)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pix(input int r, input int c);
        return 8'(r * 16 + c);
    endfunction

    // Line buffer (one-cycle read latency) and 3x3 window register model.
    logic [7:0] lb_col, lb_row;
    logic [7:0] win [3][3];
    always @(posedge clk) begin
        lb_col <= rd_col;
        lb_row <= rd_row;
        if (!Rst_window) begin
            for (int k = 0; k < 3; k++)
                for (int j = 0; j < 3; j++) win[k][j] <= 8'd0;
        end else if (Shift_window) begin
            for (int k = 0; k < 3; k++) begin
                win[k][2] <= win[k][1];
                win[k][1] <= win[k][0];
                win[k][0] <= pix(int'(lb_row) - 2 + k, int'(lb_col));
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One 4x4 frame: optional stall on the first window, optional start pulses while busy.
    task automatic run_frame(input int stall_n, input bit start_busy, input int exp_done);
        int nwin, dcyc, stall_left, nclr, bad;
        nwin = 0; dcyc = -1; stall_left = stall_n; nclr = 0;
        start = 1'b1;
        @(negedge clk);
        for (int cyc = 1; cyc <= 80 && dcyc < 0; cyc++) begin
            start = start_busy && (cyc >= 3) && (cyc <= 6);
            out_ready = 1'b1;
            if (!Rst_window) begin
                chk("clear_cycle", cyc, (nclr == 0) ? 1 : 12 + stall_n);
                nclr++;
            end
            if (window_valid) begin
                if (stall_left > 0) begin
                    out_ready = 1'b0;
                    chk("stall_out_col", out_col, 0);
                    chk("stall_out_row", out_row, 0);
                    chk("stall_rd_en", rd_en, 0);
                    chk("stall_wr", Wr_window, 0);
                    stall_left--;
                end else begin
                    chk("win_row", out_row, nwin / 2);
                    chk("win_col", out_col, nwin % 2);
                    bad = 0;
                    for (int k = 0; k < 3; k++)
                        for (int j = 0; j < 3; j++)
                            if (win[k][j] !== pix(nwin / 2 + k, nwin % 2 + 2 - j)) bad++;
                    chk("win_contents", bad, 0);
                    nwin++;
                end
            end
            if (done) dcyc = cyc;
            @(negedge clk);
        end
        start = 1'b0;
        out_ready = 1'b1;
        chk("window_count", nwin, 4);
        chk("done_cycle", dcyc, exp_done);
        chk("clear_count", nclr, 2);
    endtask

    initial begin
        int dcyc, nwin, nclr;
        clk = 1'b0; Rst_ctrl = 1'b0; start = 1'b0; start_b = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_rd_col", rd_col, 0);
        chk("rst_rd_row", rd_row, 0);
        chk("rst_wr", Wr_window, 0);
        chk("rst_shift", Shift_window, 0);
        chk("rst_rst_window", Rst_window, 1);
        chk("rst_valid", window_valid, 0);
        chk("rst_out_row", out_row, 0);
        chk("rst_out_col", out_col, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        Rst_ctrl = 1'b1;
        @(negedge clk);

        run_frame(0, 1'b0, 23);
        chk("idle_after_done", busy, 0);
        run_frame(5, 1'b0, 28);
        run_frame(0, 1'b1, 23);

        // start held high: relaunch straight after DONE
        start = 1'b1;
        @(negedge clk);
        dcyc = -1;
        for (int cyc = 1; cyc <= 60 && dcyc < 0; cyc++) begin
            if (done) dcyc = cyc;
            else @(negedge clk);
        end
        chk("held_done_cycle", dcyc, 23);
        @(negedge clk);
        chk("held_idle_busy", busy, 0);
        @(negedge clk);
        chk("held_relaunch_clear", Rst_window, 0);
        start = 1'b0;

        // controller reset during the second band's LOAD (cycle 14)
        repeat (13) @(negedge clk);
        chk("pre_rst_load", Wr_window, 1);
        Rst_ctrl = 1'b0;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_valid", window_valid, 0);
        chk("midrst_rd_en", rd_en, 0);
        Rst_ctrl = 1'b1;
        @(negedge clk);
        run_frame(0, 1'b0, 23);

        // 3x5 image: one window per band
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        dcyc = -1; nwin = 0; nclr = 0;
        for (int cyc = 1; cyc <= 60 && dcyc < 0; cyc++) begin
            if (!Rst_window_b) begin
                chk("b_clear_cycle", cyc, 1 + 8 * nclr);
                nclr++;
            end
            if (valid_b) begin
                chk("b_out_row", out_row_b, nwin);
                chk("b_out_col", out_col_b, 0);
                nwin++;
            end
            if (done_b) dcyc = cyc;
            @(negedge clk);
        end
        chk("b_window_count", nwin, 3);
        chk("b_clear_count", nclr, 3);
        chk("b_done_cycle", dcyc, 25);
        chk("b_idle_busy", busy_b, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
